// File: rtl/sound_mailbox_if.sv
// Bus bundle between the 68k decode, the 6502 decode and the sound mailbox.
// The mailbox is the slave; whatever drives both CPU sides uses the master view.
interface sound_mailbox_if;
   logic       main_wr_b;
   logic       main_rd_b;
   logic [7:0] main_din;
   logic [7:0] main_dout;
   logic [2:0] main_stat;
   logic       main_irq_b;
   logic       snd_rst_req;
   logic       snd_wr_b;
   logic       snd_rd_b;
   logic [7:0] snd_din;
   logic [7:0] snd_dout;
   logic [2:0] snd_stat;
   logic       SNDNMI_b;
   logic       SNDRST_b;

   modport master (
      output main_wr_b, main_rd_b, main_din, snd_rst_req, snd_wr_b, snd_rd_b, snd_din,
      input  main_dout, main_stat, main_irq_b, snd_dout, snd_stat, SNDNMI_b, SNDRST_b
   );

   modport slave (
      input  main_wr_b, main_rd_b, main_din, snd_rst_req, snd_wr_b, snd_rd_b, snd_din,
      output main_dout, main_stat, main_irq_b, snd_dout, snd_stat, SNDNMI_b, SNDRST_b
   );
endinterface

// File: rtl/sound_mailbox.sv
// Command/response latch pair between the 68010 and the 6502 sound CPU,
// with the 6502 NMI pulse and the sound-CPU reset stretcher.
module sound_mailbox #(
   parameter int NMI_CYCLES = 4,
   parameter int RST_CYCLES = 64,
   parameter int CNT_W      = 8
) (
   input logic             clk,
   input logic             rst_b,
   sound_mailbox_if.slave  bus
);

   localparam logic [CNT_W-1:0] NMI_LOAD = CNT_W'(NMI_CYCLES);
   localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES);

   logic             main_wr_q, main_rd_q, snd_wr_q, snd_rd_q, rst_req_q;
   logic             main_wr_d, main_rd_d, snd_wr_d, snd_rd_d, rst_req_d;
   logic [7:0]       cmd_data_q, cmd_data_d, rsp_data_q, rsp_data_d;
   logic             cmd_full_q, cmd_full_d, cmd_ovr_q, cmd_ovr_d;
   logic             rsp_full_q, rsp_full_d, rsp_ovr_q, rsp_ovr_d;
   logic [CNT_W-1:0] nmi_cnt_q, nmi_cnt_d, rst_cnt_q, rst_cnt_d;
   logic             sndnmi_b_q, sndnmi_b_d, sndrst_b_q, sndrst_b_d;
   logic             main_irq_b_q, main_irq_b_d;

   logic rst_active;
   logic mw_ev, mr_ev, sw_ev, sr_ev;

   always_comb begin
      main_wr_d = bus.main_wr_b;
      main_rd_d = bus.main_rd_b;
      snd_wr_d  = bus.snd_wr_b;
      snd_rd_d  = bus.snd_rd_b;
      rst_req_d = bus.snd_rst_req;

      rst_cnt_d = rst_cnt_q;
      if (bus.snd_rst_req && !rst_req_q)
         rst_cnt_d = RST_LOAD;
      else if (rst_cnt_q != '0)
         rst_cnt_d = rst_cnt_q - 1'b1;

      // Events are qualified with the next counter value so a reset request
      // blanks the flags on the same edge it is recognised.
      rst_active = (rst_cnt_d != '0);
      mw_ev = main_wr_q & ~bus.main_wr_b & ~rst_active;
      mr_ev = main_rd_q & ~bus.main_rd_b & ~rst_active;
      sw_ev = snd_wr_q  & ~bus.snd_wr_b  & ~rst_active;
      sr_ev = snd_rd_q  & ~bus.snd_rd_b  & ~rst_active;

      cmd_data_d = cmd_data_q;
      cmd_full_d = cmd_full_q;
      cmd_ovr_d  = cmd_ovr_q;
      if (mw_ev) begin
         cmd_data_d = bus.main_din;
         cmd_full_d = 1'b1;
         if (cmd_full_q && !sr_ev)
            cmd_ovr_d = 1'b1;
      end else if (sr_ev) begin
         cmd_full_d = 1'b0;
         cmd_ovr_d  = 1'b0;
      end

      rsp_data_d = rsp_data_q;
      rsp_full_d = rsp_full_q;
      rsp_ovr_d  = rsp_ovr_q;
      if (sw_ev) begin
         rsp_data_d = bus.snd_din;
         rsp_full_d = 1'b1;
         if (rsp_full_q && !mr_ev)
            rsp_ovr_d = 1'b1;
      end else if (mr_ev) begin
         rsp_full_d = 1'b0;
         rsp_ovr_d  = 1'b0;
      end

      nmi_cnt_d = nmi_cnt_q;
      if (mw_ev)
         nmi_cnt_d = NMI_LOAD;
      else if (nmi_cnt_q != '0)
         nmi_cnt_d = nmi_cnt_q - 1'b1;

      if (rst_active) begin
         cmd_full_d = 1'b0;
         cmd_ovr_d  = 1'b0;
         rsp_full_d = 1'b0;
         rsp_ovr_d  = 1'b0;
         nmi_cnt_d  = '0;
      end

      sndnmi_b_d   = (nmi_cnt_d == '0);
      sndrst_b_d   = ~rst_active;
      main_irq_b_d = ~rsp_full_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         main_wr_q    <= 1'b1;
         main_rd_q    <= 1'b1;
         snd_wr_q     <= 1'b1;
         snd_rd_q     <= 1'b1;
         rst_req_q    <= 1'b0;
         cmd_data_q   <= '0;
         rsp_data_q   <= '0;
         cmd_full_q   <= 1'b0;
         cmd_ovr_q    <= 1'b0;
         rsp_full_q   <= 1'b0;
         rsp_ovr_q    <= 1'b0;
         nmi_cnt_q    <= '0;
         rst_cnt_q    <= RST_LOAD;
         sndnmi_b_q   <= 1'b1;
         sndrst_b_q   <= 1'b0;
         main_irq_b_q <= 1'b1;
      end else begin
         main_wr_q    <= main_wr_d;
         main_rd_q    <= main_rd_d;
         snd_wr_q     <= snd_wr_d;
         snd_rd_q     <= snd_rd_d;
         rst_req_q    <= rst_req_d;
         cmd_data_q   <= cmd_data_d;
         rsp_data_q   <= rsp_data_d;
         cmd_full_q   <= cmd_full_d;
         cmd_ovr_q    <= cmd_ovr_d;
         rsp_full_q   <= rsp_full_d;
         rsp_ovr_q    <= rsp_ovr_d;
         nmi_cnt_q    <= nmi_cnt_d;
         rst_cnt_q    <= rst_cnt_d;
         sndnmi_b_q   <= sndnmi_b_d;
         sndrst_b_q   <= sndrst_b_d;
         main_irq_b_q <= main_irq_b_d;
      end
   end

   assign bus.snd_dout   = cmd_data_q;
   assign bus.main_dout  = rsp_data_q;
   assign bus.main_stat  = {cmd_ovr_q, cmd_full_q, rsp_full_q};
   assign bus.snd_stat   = {rsp_ovr_q, rsp_full_q, cmd_full_q};
   assign bus.main_irq_b = main_irq_b_q;
   assign bus.SNDNMI_b   = sndnmi_b_q;
   assign bus.SNDRST_b   = sndrst_b_q;

endmodule

// File: tb/tb_sound_mailbox.sv
// Scoreboard bench for sound_mailbox: expectations are queued as stimulus is
// driven and drained against the outputs once the DUT has produced them.
module tb_sound_mailbox;

   logic clk = 1'b0;
   logic rst_b;
   int   n_tests = 0;
   int   n_fail  = 0;

   sound_mailbox_if bus ();

   sound_mailbox #(.NMI_CYCLES(4), .RST_CYCLES(64), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef enum {S_SND_DOUT, S_MAIN_DOUT, S_MAIN_STAT, S_SND_STAT, S_IRQ, S_NMI, S_RST} sel_e;
   typedef struct {
      string       tag;
      sel_e        sel;
      logic [31:0] exp;
   } sb_item_t;

   sb_item_t sb_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] observe(sel_e s);
      case (s)
         S_SND_DOUT:  return 32'(bus.snd_dout);
         S_MAIN_DOUT: return 32'(bus.main_dout);
         S_MAIN_STAT: return 32'(bus.main_stat);
         S_SND_STAT:  return 32'(bus.snd_stat);
         S_IRQ:       return 32'(bus.main_irq_b);
         S_NMI:       return 32'(bus.SNDNMI_b);
         default:     return 32'(bus.SNDRST_b);
      endcase
   endfunction

   task automatic sb_push(input string tag, input sel_e sel, input logic [31:0] exp);
      sb_item_t it;
      it.tag = tag;
      it.sel = sel;
      it.exp = exp;
      sb_q.push_back(it);
   endtask

   task automatic sb_drain();
      sb_item_t it;
      while (sb_q.size() > 0) begin
         it = sb_q.pop_front();
         chk(it.tag, observe(it.sel), it.exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, nlow, falls, bad, i;
      logic prev;

      rst_b           = 1'b0;
      bus.main_wr_b   = 1'b1;
      bus.main_rd_b   = 1'b1;
      bus.main_din    = 8'h00;
      bus.snd_rst_req = 1'b0;
      bus.snd_wr_b    = 1'b1;
      bus.snd_rd_b    = 1'b1;
      bus.snd_din     = 8'h00;

      // Reset state and SNDRST_b stretch after rst_b release
      repeat (3) cyc();
      sb_push("rst_main_dout", S_MAIN_DOUT, 0);
      sb_push("rst_snd_dout",  S_SND_DOUT,  0);
      sb_push("rst_main_stat", S_MAIN_STAT, 0);
      sb_push("rst_snd_stat",  S_SND_STAT,  0);
      sb_push("rst_irq",       S_IRQ,       1);
      sb_push("rst_nmi",       S_NMI,       1);
      sb_push("rst_sndrst",    S_RST,       0);
      sb_drain();
      rst_b = 1'b1;
      n = 0;
      bad = 0;
      while (bus.SNDRST_b == 1'b0 && n < 200) begin
         n++;
         cyc();
         if (bus.main_stat != 0 || bus.snd_stat != 0 || bus.main_irq_b !== 1'b1 || bus.SNDNMI_b !== 1'b1)
            bad++;
      end
      chk("rst_len", n, 64);
      chk("rst_quiet", bad, 0);

      // Command write held low for 10 cycles
      bus.main_din  = 8'hA5;
      bus.main_wr_b = 1'b0;
      cyc();
      sb_push("cmd_dout", S_SND_DOUT, 8'hA5);
      sb_push("cmd_mstat", S_MAIN_STAT, 3'b010);
      sb_push("cmd_sstat", S_SND_STAT, 3'b001);
      sb_push("cmd_nmi_lo", S_NMI, 0);
      sb_drain();
      nlow = (bus.SNDNMI_b == 1'b0) ? 1 : 0;
      for (int k = 0; k < 9; k++) begin
         cyc();
         if (bus.SNDNMI_b == 1'b0) nlow++;
      end
      bus.main_wr_b = 1'b1;
      chk("cmd_nmi_len", nlow, 4);
      chk("cmd_one_event", bus.main_stat, 3'b010);
      cyc();
      bus.snd_rd_b = 1'b0;
      cyc();
      bus.snd_rd_b = 1'b1;
      sb_push("cmd_rd_mstat", S_MAIN_STAT, 0);
      sb_push("cmd_rd_sstat", S_SND_STAT, 0);
      sb_drain();
      cyc();

      // Overrun: two writes two cycles apart
      nlow = 0;
      falls = 0;
      prev = bus.SNDNMI_b;
      for (int k = 0; k < 12; k++) begin
         if (k == 0) begin bus.main_din = 8'h11; bus.main_wr_b = 1'b0; end
         if (k == 1) bus.main_wr_b = 1'b1;
         if (k == 2) begin bus.main_din = 8'h22; bus.main_wr_b = 1'b0; end
         if (k == 3) bus.main_wr_b = 1'b1;
         cyc();
         if (bus.SNDNMI_b == 1'b0) nlow++;
         if (prev == 1'b1 && bus.SNDNMI_b == 1'b0) falls++;
         prev = bus.SNDNMI_b;
      end
      chk("ovr_nmi_len", nlow, 6);
      chk("ovr_nmi_edges", falls, 1);
      sb_push("ovr_dout", S_SND_DOUT, 8'h22);
      sb_push("ovr_mstat", S_MAIN_STAT, 3'b110);
      sb_push("ovr_sstat", S_SND_STAT, 3'b001);
      sb_drain();
      bus.snd_rd_b = 1'b0;
      cyc();
      bus.snd_rd_b = 1'b1;
      sb_push("ovr_rd_mstat", S_MAIN_STAT, 0);
      sb_drain();
      cyc();

      // Response path
      bus.snd_din  = 8'h3C;
      bus.snd_wr_b = 1'b0;
      cyc();
      bus.snd_wr_b = 1'b1;
      sb_push("rsp_irq", S_IRQ, 0);
      sb_push("rsp_dout", S_MAIN_DOUT, 8'h3C);
      sb_push("rsp_mstat", S_MAIN_STAT, 3'b001);
      sb_push("rsp_sstat", S_SND_STAT, 3'b010);
      sb_drain();
      cyc();
      bus.main_rd_b = 1'b0;
      cyc();
      bus.main_rd_b = 1'b1;
      sb_push("rsp_rd_irq", S_IRQ, 1);
      sb_push("rsp_rd_mstat", S_MAIN_STAT, 0);
      sb_drain();
      cyc();

      // Collision on the command path with the latch already full
      bus.main_din  = 8'h55;
      bus.main_wr_b = 1'b0;
      cyc();
      bus.main_wr_b = 1'b1;
      cyc();
      bus.main_din  = 8'h77;
      bus.main_wr_b = 1'b0;
      bus.snd_rd_b  = 1'b0;
      cyc();
      bus.main_wr_b = 1'b1;
      bus.snd_rd_b  = 1'b1;
      sb_push("col_cmd_dout", S_SND_DOUT, 8'h77);
      sb_push("col_cmd_mstat", S_MAIN_STAT, 3'b010);
      sb_drain();
      cyc();
      bus.snd_rd_b = 1'b0;
      cyc();
      bus.snd_rd_b = 1'b1;
      cyc();

      // Collision on the response path with the latch already full
      bus.snd_din  = 8'h66;
      bus.snd_wr_b = 1'b0;
      cyc();
      bus.snd_wr_b = 1'b1;
      cyc();
      bus.snd_din   = 8'h99;
      bus.snd_wr_b  = 1'b0;
      bus.main_rd_b = 1'b0;
      cyc();
      bus.snd_wr_b  = 1'b1;
      bus.main_rd_b = 1'b1;
      sb_push("col_rsp_dout", S_MAIN_DOUT, 8'h99);
      sb_push("col_rsp_mstat", S_MAIN_STAT, 3'b001);
      sb_push("col_rsp_sstat", S_SND_STAT, 3'b010);
      sb_push("col_rsp_irq", S_IRQ, 0);
      sb_drain();
      cyc();
      bus.main_rd_b = 1'b0;
      cyc();
      bus.main_rd_b = 1'b1;
      repeat (6) cyc();

      // Sound reset mid-operation, re-requested 30 cycles in
      bus.snd_din  = 8'h5A;
      bus.snd_wr_b = 1'b0;
      cyc();
      bus.snd_wr_b  = 1'b1;
      bus.main_din  = 8'h44;
      bus.main_wr_b = 1'b0;
      cyc();
      bus.main_wr_b   = 1'b1;
      bus.snd_rst_req = 1'b1;
      cyc();
      sb_push("srst_lo", S_RST, 0);
      sb_push("srst_nmi", S_NMI, 1);
      sb_push("srst_mstat", S_MAIN_STAT, 0);
      sb_push("srst_sstat", S_SND_STAT, 0);
      sb_push("srst_irq", S_IRQ, 1);
      sb_drain();
      nlow = (bus.SNDRST_b == 1'b0) ? 1 : 0;
      bad = 0;
      i = 2;
      while (bus.SNDRST_b == 1'b0 && i < 300) begin
         if (i == 5)  bus.snd_rst_req = 1'b0;
         if (i == 10) begin bus.main_din = 8'hEE; bus.main_wr_b = 1'b0; end
         if (i == 12) bus.main_wr_b = 1'b1;
         if (i == 15) begin bus.snd_din = 8'hDD; bus.snd_wr_b = 1'b0; end
         if (i == 17) bus.snd_wr_b = 1'b1;
         if (i == 31) bus.snd_rst_req = 1'b1;
         if (i == 35) bus.snd_rst_req = 1'b0;
         if (i == 90) begin bus.main_din = 8'hBB; bus.main_wr_b = 1'b0; end
         cyc();
         if (bus.SNDRST_b == 1'b0) nlow++;
         if (bus.main_stat != 0 || bus.snd_stat != 0 || bus.main_irq_b !== 1'b1 || bus.SNDNMI_b !== 1'b1)
            bad++;
         i++;
      end
      chk("srst_len", nlow, 94);
      chk("srst_quiet", bad, 0);
      cyc();
      cyc();
      sb_push("srst_hold_cmd", S_SND_DOUT, 8'h44);
      sb_push("srst_hold_rsp", S_MAIN_DOUT, 8'h5A);
      sb_push("srst_no_event", S_MAIN_STAT, 0);
      sb_push("srst_no_nmi", S_NMI, 1);
      sb_drain();
      bus.main_wr_b = 1'b1;
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
